restoring_divider: RTL and testbench

RESTORING_DIVIDER -- requirements
Module: restoring_divider

---
 rtl/alu_pkg.sv | 13 +
 rtl/restoring_divider_rca_subtractor.sv | 27 ++
 rtl/restoring_divider.sv | 140 ++++++++++++++
 tb/tb_restoring_divider.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and FSM encoding for the restoring divider slice.
package alu_pkg;

  localparam int DIV_WIDTH  = 8;
  localparam int ITER_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ITER = 2'b01,
    DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/restoring_divider_rca_subtractor.sv
// 8-bit ripple-carry adder/subtractor: op=1 inverts y, so with c_in=1 it gives z = x - y
// and c_out=1 exactly when x >= y.
module RCA_SUBTRACTOR
  import alu_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] x,
  input  logic [DIV_WIDTH-1:0] y,
  input  logic                 op,
  input  logic                 c_in,
  output logic [DIV_WIDTH-1:0] z,
  output logic                 c_out
);

  logic [DIV_WIDTH:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < DIV_WIDTH; i++) begin : g_fa
    logic yEff;
    assign yEff         = y[i] ^ op;
    assign z[i]         = x[i] ^ yEff ^ carry[i];
    assign carry[i + 1] = (x[i] & yEff) | (carry[i] & (x[i] ^ yEff));
  end

  assign c_out = carry[DIV_WIDTH];

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Optional feature: define DIVIDER_ABORT_EN to add an abort input that cancels a running division.
module restoring_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIVIDER_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  if (WIDTH != 8) begin : g_bad_width
    $error("restoring_divider: WIDTH must be 8");
  end

  div_state_e            state_q, state_d;
  logic [WIDTH:0]        partRem_q, partRem_d;
  logic [WIDTH-1:0]      shiftQ_q, shiftQ_d;
  logic [WIDTH-1:0]      divisor_q, divisor_d;
  logic [ITER_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]      quotient_q, quotient_d;
  logic [WIDTH-1:0]      remainder_q, remainder_d;
  logic                  divByZero_q, divByZero_d;

  logic [WIDTH:0]        trialS;
  logic [WIDTH-1:0]      diff;
  logic                  carryOut;
  logic                  trialOk;
  logic [WIDTH:0]        partRemNext;
  logic [WIDTH-1:0]      shiftQNext;
  logic                  unused_remMsb;

  // The MSB of P is architecturally part of the partial remainder but is always 0 after a restore.
  assign unused_remMsb = partRem_q[WIDTH];

  assign trialS = {partRem_q[WIDTH-1:0], shiftQ_q[WIDTH-1]};

  RCA_SUBTRACTOR u_sub (
    .x     (trialS[WIDTH-1:0]),
    .y     (divisor_q),
    .op    (1'b1),
    .c_in  (1'b1),
    .z     (diff),
    .c_out (carryOut)
  );

  // A set S[WIDTH] means S exceeds any 8-bit divisor even if the subtractor borrowed.
  assign trialOk     = trialS[WIDTH] | carryOut;
  assign partRemNext = trialOk ? {1'b0, diff} : trialS;
  assign shiftQNext  = {shiftQ_q[WIDTH-2:0], trialOk};

  always_comb begin
    state_d     = state_q;
    partRem_d   = partRem_q;
    shiftQ_d    = shiftQ_q;
    divisor_d   = divisor_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    divByZero_d = divByZero_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          divisor_d = divisor;
          shiftQ_d  = dividend;
          partRem_d = '0;
          cnt_d     = '0;
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            divByZero_d = 1'b1;
          end else begin
            state_d = ITER;
          end
        end
      end
      ITER: begin
`ifdef DIVIDER_ABORT_EN
        if (abort) begin
          state_d = IDLE;
        end else
`endif
        begin
          partRem_d = partRemNext;
          shiftQ_d  = shiftQNext;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == ITER_CNT_W'(WIDTH - 1)) begin
            state_d     = DONE;
            quotient_d  = shiftQNext;
            remainder_d = partRemNext[WIDTH-1:0];
            divByZero_d = 1'b0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      partRem_q   <= '0;
      shiftQ_q    <= '0;
      divisor_q   <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      divByZero_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      partRem_q   <= partRem_d;
      shiftQ_q    <= shiftQ_d;
      divisor_q   <= divisor_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      divByZero_q <= divByZero_d;
    end
  end

  assign busy        = (state_q == ITER) || (state_q == DONE);
  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = divByZero_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed table, corner sequences and random vectors
// checked against plain integer division.
module tb_restoring_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
`ifdef DIVIDER_ABORT_EN
  logic       abort = 1'b0;
`endif
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] dvd;
    logic [7:0] dvs;
    logic [7:0] expQ;
    logic [7:0] expR;
    logic       expZ;
  } vec_t;

  vec_t vecs[8];

  restoring_divider #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef DIVIDER_ABORT_EN
    .abort       (abort),
`endif
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Reference: plain integer division, with the divide-by-zero convention.
  task automatic refDivide(input int a, input int b, output int q, output int r, output int z);
    if (b == 0) begin
      q = 255; r = a; z = 1;
    end else begin
      q = a / b; r = a % b; z = 0;
    end
  endtask

  // Drives a one-cycle start; returns at the falling edge after the capture edge E0.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges past E0 until done is seen at a falling edge, bounded.
  task automatic waitDone(input int already, output int lat, output int busyGap);
    lat = already;
    busyGap = 0;
    while (!done && lat < 20) begin
      if (!busy) busyGap = 1;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic watchNoDone(input int n, input string name);
    int seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) seen++;
    end
    checkOutput(name, seen, 0);
  endtask

  task automatic checkResult(input string name, input int q, input int r, input int z);
    checkOutput({name, ".quotient"}, quotient, q);
    checkOutput({name, ".remainder"}, remainder, r);
    checkOutput({name, ".dbz"}, div_by_zero, z);
  endtask

  task automatic runCase(input string name, input logic [7:0] a, input logic [7:0] b,
                         input int q, input int r, input int z);
    int lat, gap;
    applyStimulus(a, b);
    waitDone(0, lat, gap);
    checkOutput({name, ".latency"}, lat, (b == 0) ? 0 : 8);
    checkOutput({name, ".busyDuring"}, gap, 0);
    checkResult(name, q, r, z);
    @(negedge clk);
    checkOutput({name, ".donePulse"}, done, 0);
    checkOutput({name, ".busyAfter"}, busy, 0);
    checkResult({name, ".hold"}, q, r, z);
  endtask

  initial begin
    int lat, gap, q, r, z;
    logic [7:0] a, b;

    vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0};
    vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
    vecs[2] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
    vecs[3] = '{8'd200, 8'd255, 8'd0,   8'd200, 1'b0};
    vecs[4] = '{8'd37,  8'd0,   8'd255, 8'd37,  1'b1};
    vecs[5] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
    vecs[6] = '{8'd9,   8'd2,   8'd4,   8'd1,   1'b0};
    vecs[7] = '{8'd254, 8'd16,  8'd15,  8'd14,  1'b0};

    #3;
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.done", done, 0);
    checkResult("reset", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      runCase($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dvs,
              vecs[i].expQ, vecs[i].expR, vecs[i].expZ);
    end

    // New start with different operands mid-ITER must be ignored.
    applyStimulus(8'd100, 8'd7);
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 8'd50; divisor = 8'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    waitDone(3, lat, gap);
    checkOutput("midIter.latency", lat, 8);
    checkResult("midIter", 14, 2, 0);
    watchNoDone(12, "midIter.noExtraDone");

    // Start presented while in DONE must be ignored.
    applyStimulus(8'd200, 8'd9);
    waitDone(0, lat, gap);
    checkOutput("inDone.latency", lat, 8);
    start = 1'b1; dividend = 8'd50; divisor = 8'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkOutput("inDone.busyAfter", busy, 0);
    watchNoDone(12, "inDone.noDone");
    checkResult("inDone", 22, 2, 0);

    // Asynchronous reset mid-ITER clears everything immediately.
    applyStimulus(8'd100, 8'd7);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midReset.busy", busy, 0);
    checkOutput("midReset.done", done, 0);
    checkResult("midReset", 0, 0, 0);
    @(negedge clk);
    checkOutput("midReset.doneHeld", done, 0);
    rst_n = 1'b1; start = 1'b1; dividend = 8'd9; divisor = 8'd2;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    waitDone(0, lat, gap);
    checkOutput("afterReset.latency", lat, 8);
    checkResult("afterReset", 4, 1, 0);

`ifdef DIVIDER_ABORT_EN
    applyStimulus(8'd100, 8'd7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort.busy", busy, 0);
    checkOutput("abort.done", done, 0);
    watchNoDone(12, "abort.noDone");
    checkResult("abort", 4, 1, 0);
    runCase("afterAbort", 8'd100, 8'd7, 14, 2, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      refDivide(a, b, q, r, z);
      runCase($sformatf("rand%0d_%0d_%0d", i, a, b), a, b, q, r, z);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
